// File: rtl/dynamic_branch_predictor_if.sv
// Branch predictor bus: fetch-side lookup, decode-side resolution and perf counters.
// The master side (fetch/decode) drives lookup PCs and resolutions; the slave
// side (predictor) returns predictions, the flush request and perf counters.
interface dynamic_branch_predictor_if #(
  parameter int PC_WIDTH = 16
);
  logic [PC_WIDTH-1:0] PC_curr;
  logic                predicted_taken;
  logic [PC_WIDTH-1:0] predicted_target;
  logic                update_en;
  logic [PC_WIDTH-1:0] update_PC;
  logic                update_pred_taken;
  logic [PC_WIDTH-1:0] update_pred_target;
  logic                actual_taken;
  logic [PC_WIDTH-1:0] actual_target;
  logic                mispredict;
  logic [PC_WIDTH-1:0] redirect_PC;
  logic [31:0]         perf_lookups;
  logic [31:0]         perf_mispredicts;

  modport master (
    output PC_curr, update_en, update_PC, update_pred_taken, update_pred_target,
           actual_taken, actual_target,
    input  predicted_taken, predicted_target, mispredict, redirect_PC,
           perf_lookups, perf_mispredicts
  );

  modport slave (
    input  PC_curr, update_en, update_PC, update_pred_taken, update_pred_target,
           actual_taken, actual_target,
    output predicted_taken, predicted_target, mispredict, redirect_PC,
           perf_lookups, perf_mispredicts
  );
endinterface

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BHT of 2-bit saturating
// counters plus a tagged BTB. Lookup and mispredict detection are combinational;
// table updates happen on posedge clk from decode-stage resolutions.
// Optional feature macro: DBP_PERF_CNT_EN (lookup / mispredict perf counters).
module dynamic_branch_predictor #(
  parameter int PC_WIDTH    = 16,
  parameter int NUM_ENTRIES = 16
) (
  input logic                        clk,
  input logic                        rst,
  dynamic_branch_predictor_if.slave  bp
);
  localparam int IDX_BITS = $clog2(NUM_ENTRIES);
  localparam int TAG_BITS = PC_WIDTH - IDX_BITS - 1;

  // Saturating 2-bit counter step: 00 SNT, 01 WNT, 10 WT, 11 ST.
  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return res;
  endfunction

  logic                valid_r  [NUM_ENTRIES];
  logic [TAG_BITS-1:0] tag_r    [NUM_ENTRIES];
  logic [PC_WIDTH-1:0] target_r [NUM_ENTRIES];
  logic [1:0]          cnt_r    [NUM_ENTRIES];

  logic [IDX_BITS-1:0] look_idx_s;
  logic [TAG_BITS-1:0] look_tag_s;
  logic                look_hit_s;
  logic [IDX_BITS-1:0] upd_idx_s;
  logic [TAG_BITS-1:0] upd_tag_s;
  logic                upd_hit_s;
  logic [1:0]          upd_cnt_s;

  assign look_idx_s = bp.PC_curr[IDX_BITS:1];
  assign look_tag_s = bp.PC_curr[PC_WIDTH-1:IDX_BITS+1];
  assign upd_idx_s  = bp.update_PC[IDX_BITS:1];
  assign upd_tag_s  = bp.update_PC[PC_WIDTH-1:IDX_BITS+1];

  // Lookup reads the current (pre-update) table contents; no write bypass.
  always_comb begin
    look_hit_s          = valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s);
    bp.predicted_taken  = look_hit_s && cnt_r[look_idx_s][1];
    if (bp.predicted_taken) begin
      bp.predicted_target = target_r[look_idx_s];
    end else begin
      bp.predicted_target = bp.PC_curr + PC_WIDTH'(2);
    end
  end

  // Mispredict detection against the prediction carried down with the branch.
  always_comb begin
    bp.mispredict  = 1'b0;
    bp.redirect_PC = {PC_WIDTH{1'b0}};
    if (bp.update_en) begin
      bp.mispredict = (bp.update_pred_taken != bp.actual_taken) ||
                      (bp.actual_taken && (bp.update_pred_target != bp.actual_target));
      if (bp.actual_taken) begin
        bp.redirect_PC = bp.actual_target;
      end else begin
        bp.redirect_PC = bp.update_PC + PC_WIDTH'(2);
      end
    end else begin
      bp.mispredict  = 1'b0;
      bp.redirect_PC = {PC_WIDTH{1'b0}};
    end
  end

  // Update-side hit and next counter value for the resolved branch's entry.
  always_comb begin
    upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    upd_cnt_s = sat_cnt(cnt_r[upd_idx_s], bp.actual_taken);
  end

  // Table state: reset clears everything; a hit trains, a taken miss allocates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_BITS{1'b0}};
        target_r[i] <= {PC_WIDTH{1'b0}};
        cnt_r[i]    <= 2'b01;
      end
    end else if (bp.update_en) begin
      if (upd_hit_s) begin
        cnt_r[upd_idx_s] <= upd_cnt_s;
        if (bp.actual_taken) begin
          target_r[upd_idx_s] <= bp.actual_target;
        end
      end else if (bp.actual_taken) begin
        valid_r[upd_idx_s]  <= 1'b1;
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= bp.actual_target;
        cnt_r[upd_idx_s]    <= 2'b10;
      end
      // Not-taken misses leave the table untouched.
    end
  end

`ifdef DBP_PERF_CNT_EN
  logic [31:0] perf_lookups_r;
  logic [31:0] perf_mispredicts_r;

  // Wrapping perf counters for resolved branches and mispredicts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_lookups_r     <= 32'd0;
      perf_mispredicts_r <= 32'd0;
    end else begin
      if (bp.update_en) begin
        perf_lookups_r <= perf_lookups_r + 32'd1;
      end
      if (bp.mispredict) begin
        perf_mispredicts_r <= perf_mispredicts_r + 32'd1;
      end
    end
  end

  assign bp.perf_lookups     = perf_lookups_r;
  assign bp.perf_mispredicts = perf_mispredicts_r;
`else
  assign bp.perf_lookups     = 32'd0;
  assign bp.perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Directed self-checking bench for dynamic_branch_predictor (16 entries, 16-bit PC).
module tb_dynamic_branch_predictor;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  dynamic_branch_predictor_if #(.PC_WIDTH(16)) bus ();

  dynamic_branch_predictor #(.PC_WIDTH(16), .NUM_ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [15:0] pc, input logic exp_t,
                      input logic [15:0] exp_tgt);
    bus.PC_curr = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, bus.predicted_taken}, {31'd0, exp_t});
    chk({tag, "_target"}, {16'd0, bus.predicted_target}, {16'd0, exp_tgt});
  endtask

  // Drive one resolution, check the combinational flush outputs, then clock it in.
  task automatic upd(input string tag, input logic [15:0] pc, input logic pt,
                     input logic [15:0] ptgt, input logic at, input logic [15:0] atgt,
                     input logic exp_mis, input logic [15:0] exp_redir);
    bus.update_en          = 1'b1;
    bus.update_PC          = pc;
    bus.update_pred_taken  = pt;
    bus.update_pred_target = ptgt;
    bus.actual_taken       = at;
    bus.actual_target      = atgt;
    #1;
    chk({tag, "_mispredict"}, {31'd0, bus.mispredict}, {31'd0, exp_mis});
    chk({tag, "_redirect"}, {16'd0, bus.redirect_PC}, {16'd0, exp_redir});
    @(posedge clk);
    #1;
    bus.update_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    bus.PC_curr            = 16'h0000;
    bus.update_en          = 1'b0;
    bus.update_PC          = 16'h0000;
    bus.update_pred_taken  = 1'b0;
    bus.update_pred_target = 16'h0000;
    bus.actual_taken       = 1'b0;
    bus.actual_target      = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    look("rst_look", 16'h0010, 1'b0, 16'h0012);
    chk("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
    chk("rst_redirect", {16'd0, bus.redirect_PC}, 32'd0);
    chk("rst_perf_lookups", bus.perf_lookups, 32'd0);
    chk("rst_perf_mispredicts", bus.perf_mispredicts, 32'd0);

    // Allocate on taken miss; same-cycle lookup of that index sees the old entry
    bus.PC_curr = 16'h0010;
    bus.update_en = 1'b1;
    bus.update_PC = 16'h0010;
    bus.update_pred_taken = 1'b0;
    bus.update_pred_target = 16'h0012;
    bus.actual_taken = 1'b1;
    bus.actual_target = 16'h0040;
    #1;
    chk("same_cycle_old_taken", {31'd0, bus.predicted_taken}, 32'd0);
    chk("same_cycle_old_target", {16'd0, bus.predicted_target}, 32'h0012);
    chk("alloc_mispredict", {31'd0, bus.mispredict}, 32'd1);
    chk("alloc_redirect", {16'd0, bus.redirect_PC}, 32'h0040);
    @(posedge clk);
    #1;
    bus.update_en = 1'b0;
    #1;
    chk("idle_mispredict", {31'd0, bus.mispredict}, 32'd0);
    chk("idle_redirect", {16'd0, bus.redirect_PC}, 32'd0);
    look("alloc_look", 16'h0010, 1'b1, 16'h0040);

    // Saturation: 10 -> 11 -> 11, then 11 -> 10 (still taken) -> 01 (not taken)
    upd("sat_t1", 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0040);
    upd("sat_t2", 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0040);
    upd("sat_nt1", 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0012);
    look("sat_after_nt1", 16'h0010, 1'b1, 16'h0040);
    upd("sat_nt2", 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0012);
    look("sat_after_nt2", 16'h0010, 1'b0, 16'h0012);

    // Retrain taken (01 -> 10), then alias 0x0030 onto the same index
    upd("retrain", 16'h0010, 1'b0, 16'h0012, 1'b1, 16'h0040, 1'b1, 16'h0040);
    look("retrain_look", 16'h0010, 1'b1, 16'h0040);
    look("alias_miss", 16'h0030, 1'b0, 16'h0032);
    upd("alias_alloc", 16'h0030, 1'b0, 16'h0032, 1'b1, 16'h0100, 1'b1, 16'h0100);
    look("alias_evicted", 16'h0010, 1'b0, 16'h0012);
    look("alias_new", 16'h0030, 1'b1, 16'h0100);

    // Not-taken miss does not allocate
    upd("nt_miss", 16'h0020, 1'b0, 16'h0022, 1'b0, 16'h0000, 1'b0, 16'h0022);
    look("nt_miss_look", 16'h0020, 1'b0, 16'h0022);

    // Target mismatch with correct direction
    upd("tgt_mis", 16'h0030, 1'b1, 16'h0040, 1'b1, 16'h0050, 1'b1, 16'h0050);
    look("tgt_mis_look", 16'h0030, 1'b1, 16'h0050);

    // Fall-through wrap at the top of the address space
    look("wrap", 16'hFFFE, 1'b0, 16'h0000);

    // Reset takes priority over a concurrent update
    rst = 1'b0;
    bus.update_en = 1'b1;
    bus.update_PC = 16'h0030;
    bus.update_pred_taken = 1'b0;
    bus.update_pred_target = 16'h0032;
    bus.actual_taken = 1'b1;
    bus.actual_target = 16'h0200;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.update_en = 1'b0;
    look("rst_upd_0030", 16'h0030, 1'b0, 16'h0032);
    look("rst_upd_0010", 16'h0010, 1'b0, 16'h0012);
    chk("rst_upd_perf_lookups", bus.perf_lookups, 32'd0);
    chk("rst_upd_perf_mispredicts", bus.perf_mispredicts, 32'd0);

    // Five resolutions, two of them mispredicted
    upd("perf_u1", 16'h0100, 1'b0, 16'h0102, 1'b1, 16'h0200, 1'b1, 16'h0200);
    upd("perf_u2", 16'h0100, 1'b1, 16'h0200, 1'b1, 16'h0200, 1'b0, 16'h0200);
    upd("perf_u3", 16'h0100, 1'b1, 16'h0200, 1'b1, 16'h0200, 1'b0, 16'h0200);
    upd("perf_u4", 16'h0100, 1'b1, 16'h0200, 1'b0, 16'h0000, 1'b1, 16'h0102);
    upd("perf_u5", 16'h0100, 1'b0, 16'h0102, 1'b0, 16'h0000, 1'b0, 16'h0102);
    look("perf_final_look", 16'h0100, 1'b0, 16'h0102);
`ifdef DBP_PERF_CNT_EN
    chk("perf_lookups", bus.perf_lookups, 32'd5);
    chk("perf_mispredicts", bus.perf_mispredicts, 32'd2);
`else
    chk("perf_lookups_tied", bus.perf_lookups, 32'd0);
    chk("perf_mispredicts_tied", bus.perf_mispredicts, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
